// File: rtl/output_mem_ctrl.sv
// Output-memory write sequencer: 1-edge accept-to-write, frame_done 2 edges after last accept; res_ready low outside COLLECT.
// Optional idle-timeout abort compiled in with `define OUT_CTRL_TIMEOUT_EN.
module output_mem_ctrl #(
  parameter int N_WORDS     = 4,
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              Clock,
  input  logic              Res,
  input  logic              start,
  input  logic              done_ack,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  output logic              En_out_mem,
  output logic [ADDR_W-1:0] Addr_mem_o,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] word_cnt,
  output logic              timeout_err
);

  // word_cnt must be able to hold N_WORDS itself.
  if (N_WORDS < 2 || N_WORDS > 4 || TIMEOUT_CYC < 1 || N_WORDS >= (1 << ADDR_W)) begin : g_param_check
    $error("output_mem_ctrl: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_res_ready;
  logic                r_en;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_frame_done;
  logic [ADDR_W-1:0]   r_word_cnt;
  logic                w_accept;
  logic                w_last;
  logic                w_timeout;

  assign w_accept = (r_state == S_COLLECT) && res_valid && r_res_ready;
  assign w_last   = (r_word_cnt == ADDR_W'(N_WORDS - 1));

`ifdef OUT_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] r_idle_cnt;
  logic          r_timeout_err;

  // Held at zero outside COLLECT, so every entry to COLLECT starts a fresh count.
  always_ff @(posedge Clock) begin
    if (!Res) begin
      r_idle_cnt <= '0;
    end else if (r_state != S_COLLECT || w_accept) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_COLLECT) && !w_accept &&
                     (r_idle_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge Clock) begin
    if (!Res) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end else if (r_state == S_DONE && done_ack) begin
      r_timeout_err <= 1'b0;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (!Res) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_COLLECT;
      S_COLLECT: begin
        if (w_accept && w_last) begin
          w_next = S_FLUSH;
        end else if (w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_FLUSH:   w_next = S_DONE;
      S_DONE:    if (done_ack) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Handshake flags follow the next state so they are valid from the first cycle of each state.
  always_ff @(posedge Clock) begin
    if (!Res) begin
      r_res_ready  <= 1'b0;
      r_en         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_frame_done <= 1'b0;
      r_word_cnt   <= '0;
    end else begin
      r_res_ready  <= (w_next == S_COLLECT);
      r_frame_done <= (w_next == S_DONE);
      r_en         <= w_accept;
      if (w_accept) begin
        r_addr     <= r_word_cnt;
        r_wdata    <= res_data;
        r_word_cnt <= r_word_cnt + 1'b1;
      end else if ((r_state == S_IDLE && start) || (r_state == S_DONE && done_ack)) begin
        r_word_cnt <= '0;
      end
    end
  end

  assign res_ready  = r_res_ready;
  assign En_out_mem = r_en;
  assign Addr_mem_o = r_addr;
  assign wr_data    = r_wdata;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;
  assign word_cnt   = r_word_cnt;

endmodule
